// File: rtl/audio_delay_proc.sv
// Sample-rate audio delay/echo engine: a tick divider, ADC handshake, circular sample buffer and DAC word output.
// Define AUDIO_DELAY_ECHO_EN to build the recursive echo path; otherwise the block is a pure delay line.
//
// state    | meaning
// IDLE     | waiting for the sample tick; the tick raises adc_start
// WAIT_ADC | conversion requested; capture the sample and delay on adc_valid
// READ     | synchronous buffer read in flight
// CALC     | form the output word and the value to store, load the DAC
// WRITE    | commit to the buffer, advance wr_ptr and fill
module audio_delay_proc #(
  parameter int DW      = 10,
  parameter int AW      = 13,
  parameter int CLK_DIV = 2500
) (
  input  logic          sysclk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [AW-1:0] delay,
  output logic          adc_start,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  output logic [DW-1:0] dac_data,
  output logic          dac_load,
  output logic          overrun,
  output logic [AW-1:0] fill
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_TOP  = CW'(CLK_DIV - 1);
  localparam logic [DW-1:0] MID      = {1'b1, {(DW-1){1'b0}}};
  localparam logic [AW-1:0] FILL_MAX = '1;

  typedef enum logic [2:0] {IDLE, WAIT_ADC, READ, CALC, WRITE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [DW-1:0] xs;
  logic [DW-1:0] yd;
  logic [DW-1:0] out_nx;
  logic [DW-1:0] store_nx;
  logic [DW-1:0] store;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] dly;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;
  logic          mem_we;
  logic [DW-1:0] mem [2**AW];

  // Down-counter from CLK_DIV-1; the tick is its terminal count of zero.
  assign tick      = (cnt == '0);
  assign adc_start = tick && enable && (state == IDLE);
  assign mem_we    = rst_n && (state == WRITE);

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      cnt <= CNT_TOP;
    end else if (!enable || tick) begin
      cnt <= CNT_TOP;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  // Buffer contents are never reset; fill gating hides stale entries.
  always_ff @(posedge sysclk) begin
    if (mem_we) begin
      mem[wr_ptr] <= store;
    end
    rd_data <= mem[rd_addr];
  end

`ifdef AUDIO_DELAY_ECHO_EN
  logic [DW:0]   sum;
  logic [DW-1:0] ys;
`endif

  always_comb begin
    yd = (fill < dly || dly == '0) ? '0 : rd_data;
`ifdef AUDIO_DELAY_ECHO_EN
    sum = {xs[DW-1], xs} + {yd[DW-1], yd[DW-1], yd[DW-1:1]};
    if (sum[DW] != sum[DW-1]) begin
      ys = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      ys = sum[DW-1:0];
    end
    store_nx = ys;
    out_nx   = ys;
`else
    store_nx = xs;
    out_nx   = (dly == '0) ? xs : yd;
`endif
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state    <= IDLE;
      xs       <= '0;
      dly      <= '0;
      rd_addr  <= '0;
      wr_ptr   <= '0;
      fill     <= '0;
      store    <= '0;
      dac_data <= MID;
      dac_load <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      dac_load <= 1'b0;
      if (tick && state != IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (tick && enable) begin
            state <= WAIT_ADC;
          end
        end
        WAIT_ADC: begin
          if (adc_valid) begin
            xs      <= {~adc_data[DW-1], adc_data[DW-2:0]};
            dly     <= delay;
            rd_addr <= wr_ptr - delay;
            state   <= READ;
          end
        end
        READ: begin
          state <= CALC;
        end
        CALC: begin
          store    <= store_nx;
          dac_data <= {~out_nx[DW-1], out_nx[DW-2:0]};
          dac_load <= 1'b1;
          state    <= WRITE;
        end
        WRITE: begin
          wr_ptr <= wr_ptr + AW'(1);
          if (fill != FILL_MAX) begin
            fill <= fill + AW'(1);
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_delay_proc.sv
// Bench for audio_delay_proc: an ADC responder feeds samples, a monitor logs DAC loads, and each test
// compares the log against a sample-history model of the delay/echo rules.
module tb_audio_delay_proc;

  localparam int DW      = 10;
  localparam int AW      = 4;
  localparam int CLK_DIV = 8;

  logic          sysclk;
  logic          rst_n;
  logic          enable;
  logic [AW-1:0] delay;
  logic          adc_start;
  logic [DW-1:0] adc_data;
  logic          adc_valid;
  logic [DW-1:0] dac_data;
  logic          dac_load;
  logic          overrun;
  logic [AW-1:0] fill;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int adc_lat = 2;

  int            x_log[$];
  int            d_log[$];
  int            v_cyc[$];
  int            l_cyc[$];
  int            s_cyc[$];
  logic [DW-1:0] o_log[$];
  int            exp_q[$];

  int stim_a[64];
  int stim_n    = 0;
  int stim_base = 0;
  int xb = 0;
  int ob = 0;
  int sb = 0;

  audio_delay_proc #(.DW(DW), .AW(AW), .CLK_DIV(CLK_DIV)) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .enable    (enable),
    .delay     (delay),
    .adc_start (adc_start),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .dac_data  (dac_data),
    .dac_load  (dac_load),
    .overrun   (overrun),
    .fill      (fill)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (dac_load === 1'b1) begin
      o_log.push_back(dac_data);
      l_cyc.push_back(cyc);
    end
    if (adc_start === 1'b1) s_cyc.push_back(cyc);
  end

  // ADC model: valid arrives adc_lat cycles after the start strobe
  initial begin : adc_model
    int k;
    adc_valid = 1'b0;
    adc_data  = '0;
    forever begin
      @(negedge sysclk);
      if (adc_start === 1'b1) begin
        repeat (adc_lat) @(posedge sysclk);
        #1;
        k = x_log.size() - stim_base;
        if (k >= 0 && k < stim_n) adc_data = DW'(stim_a[k]);
        else adc_data = DW'($urandom_range(0, 1023));
        adc_valid = 1'b1;
        x_log.push_back(int'(adc_data));
        v_cyc.push_back(cyc);
        @(posedge sysclk);
        d_log.push_back(int'(delay));
        #1 adc_valid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference: y[n] history since reset; missing history (n < d) or d == 0 gives a zero echo term.
  function automatic void compute_model();
    int y[$];
    int x, d, yd, v;
    exp_q.delete();
    for (int n = 0; xb + n < x_log.size(); n++) begin
      x  = x_log[xb + n] - 512;
      d  = d_log[xb + n];
      yd = (d == 0 || n < d) ? 0 : y[n - d];
`ifdef AUDIO_DELAY_ECHO_EN
      v = x + (yd >>> 1);
      if (v > 511) v = 511;
      if (v < -512) v = -512;
      y.push_back(v);
`else
      y.push_back(x);
      v = (d == 0) ? x : yd;
`endif
      exp_q.push_back(v + 512);
    end
  endfunction

  task automatic do_reset();
    @(posedge sysclk);
    #1;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge sysclk);
    #1 rst_n = 1'b1;
    xb = x_log.size();
    ob = o_log.size();
    sb = s_cyc.size();
  endtask

  task automatic set_stim(input int first, input int n, input int step, input int n2, input int v2);
    for (int i = 0; i < n; i++) stim_a[i] = first + i * step;
    for (int i = 0; i < n2; i++) stim_a[n + i] = v2;
    stim_n    = n + n2;
    stim_base = x_log.size();
  endtask

  task automatic run_samples(input int n, input bit rand_d);
    int target, t;
    target = x_log.size() + n;
    @(posedge sysclk);
    #1 enable = 1'b1;
    t = 0;
    while (x_log.size() < target && t < n * CLK_DIV * 3 + 50) begin
      @(negedge sysclk);
      t++;
      if (rand_d && $urandom_range(0, 3) == 0) delay = AW'($urandom_range(0, 15));
    end
    if (x_log.size() < target) begin
      total++; bad++;
      $display("FAIL run_timeout samples got %0d want %0d", x_log.size() - (target - n), n);
    end
    @(posedge sysclk);
    #1 enable = 1'b0;
    t = 0;
    while (((s_cyc.size() - sb) != (x_log.size() - xb) || (x_log.size() - xb) != (o_log.size() - ob)) && t < 60) begin
      @(negedge sysclk);
      t++;
    end
    repeat (2) @(negedge sysclk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; delay = '0;
    repeat (3) @(posedge sysclk);
    #1 rst_n = 1'b1;
    xb = x_log.size(); ob = o_log.size(); sb = s_cyc.size();
    repeat (40) @(negedge sysclk);
    total++; if (dac_data !== 10'd512) begin bad++; $display("FAIL reset_dac_data got %0d want 512", dac_data); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got %b want 0", overrun); end
    total++; if (fill !== 4'd0) begin bad++; $display("FAIL reset_fill got %0d want 0", fill); end
    total++; if (adc_start !== 1'b0) begin bad++; $display("FAIL reset_adc_start got %b want 0", adc_start); end
    total++; if (dac_load !== 1'b0) begin bad++; $display("FAIL reset_dac_load got %b want 0", dac_load); end
    total++; if (s_cyc.size() != sb) begin bad++; $display("FAIL reset_no_start got %0d starts want 0", s_cyc.size() - sb); end
    total++; if (o_log.size() != ob) begin bad++; $display("FAIL reset_no_load got %0d loads want 0", o_log.size() - ob); end
  endtask

  task automatic test_ramp();
    do_reset();
    delay = AW'(3);
    set_stim(600, 12, 1, 0, 0);
    run_samples(12, 1'b0);
    compute_model();
    total++; if (o_log.size() - ob != 12) begin bad++; $display("FAIL ramp_count got %0d want 12", o_log.size() - ob); end
    for (int i = 0; i < 12; i++) begin
      total++; if (o_log[ob + i] !== DW'(exp_q[i])) begin bad++; $display("FAIL ramp_out[%0d] got %0d want %0d", i, o_log[ob + i], exp_q[i]); end
      total++; if (l_cyc[ob + i] - v_cyc[xb + i] != 3) begin bad++; $display("FAIL ramp_latency[%0d] got %0d want 3", i, l_cyc[ob + i] - v_cyc[xb + i]); end
    end
`ifndef AUDIO_DELAY_ECHO_EN
    for (int i = 0; i < 6; i++) begin
      total++; if (o_log[ob + i] !== DW'((i < 3) ? 512 : 597 + i)) begin bad++; $display("FAIL ramp_table[%0d] got %0d want %0d", i, o_log[ob + i], (i < 3) ? 512 : 597 + i); end
    end
`endif
    total++; if (fill !== 4'd12) begin bad++; $display("FAIL ramp_fill got %0d want 12", fill); end
  endtask

  task automatic test_random_delay();
    do_reset();
    stim_n = 0;
    delay = AW'(5);
    run_samples(30, 1'b1);
    compute_model();
    total++; if (o_log.size() - ob != 30) begin bad++; $display("FAIL rdelay_count got %0d want 30", o_log.size() - ob); end
    for (int i = 0; i < 30; i++) begin
      total++; if (o_log[ob + i] !== DW'(exp_q[i])) begin bad++; $display("FAIL rdelay_out[%0d] d=%0d got %0d want %0d", i, d_log[xb + i], o_log[ob + i], exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    stim_n = 0;
    delay = AW'(15);
    run_samples(40, 1'b0);
    compute_model();
    total++; if (o_log.size() - ob != 40) begin bad++; $display("FAIL wrap_count got %0d want 40", o_log.size() - ob); end
    for (int i = 0; i < 40; i++) begin
      total++; if (o_log[ob + i] !== DW'(exp_q[i])) begin bad++; $display("FAIL wrap_out[%0d] got %0d want %0d", i, o_log[ob + i], exp_q[i]); end
    end
`ifndef AUDIO_DELAY_ECHO_EN
    for (int i = 15; i < 40; i += 6) begin
      total++; if (o_log[ob + i] !== DW'(x_log[xb + i - 15])) begin bad++; $display("FAIL wrap_history[%0d] got %0d want %0d", i, o_log[ob + i], x_log[xb + i - 15]); end
    end
`endif
    total++; if (fill !== 4'd15) begin bad++; $display("FAIL wrap_fill got %0d want 15", fill); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL wrap_overrun got %b want 0", overrun); end
  endtask

  task automatic test_echo();
    int tab[7];
`ifdef AUDIO_DELAY_ECHO_EN
    tab = '{768, 512, 640, 512, 576, 512, 544};
`else
    tab = '{512, 512, 768, 512, 512, 512, 512};
`endif
    do_reset();
    delay = AW'(2);
    set_stim(768, 1, 0, 11, 512);
    run_samples(12, 1'b0);
    compute_model();
    for (int i = 0; i < 12; i++) begin
      total++; if (o_log[ob + i] !== DW'(exp_q[i])) begin bad++; $display("FAIL echo_out[%0d] got %0d want %0d", i, o_log[ob + i], exp_q[i]); end
    end
    for (int i = 0; i < 7; i++) begin
      total++; if (o_log[ob + i] !== DW'(tab[i])) begin bad++; $display("FAIL echo_table[%0d] got %0d want %0d", i, o_log[ob + i], tab[i]); end
    end
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    delay = AW'(2);
    set_stim(1023, 10, 0, 10, 0);
    run_samples(20, 1'b0);
    compute_model();
    for (int i = 0; i < 20; i++) begin
      total++; if (o_log[ob + i] !== DW'(exp_q[i])) begin bad++; $display("FAIL sat_out[%0d] got %0d want %0d", i, o_log[ob + i], exp_q[i]); end
    end
    for (int i = 0; i < 10; i++) begin
`ifdef AUDIO_DELAY_ECHO_EN
      want = 1023;
`else
      want = (i < 2) ? 512 : 1023;
`endif
      total++; if (o_log[ob + i] !== DW'(want)) begin bad++; $display("FAIL sat_table[%0d] got %0d want %0d", i, o_log[ob + i], want); end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    stim_n = 0;
    delay = AW'(1);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_initial got %b want 0", overrun); end
    adc_lat = 12;
    run_samples(1, 1'b0);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got %b want 1", overrun); end
    total++; if (s_cyc.size() - sb != 1) begin bad++; $display("FAIL ovr_missed_tick_start got %0d starts want 1", s_cyc.size() - sb); end
    adc_lat = 2;
    run_samples(4, 1'b0);
    compute_model();
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    total++; if (s_cyc.size() - sb != 5) begin bad++; $display("FAIL ovr_starts got %0d want 5", s_cyc.size() - sb); end
    for (int i = 0; i < 5; i++) begin
      total++; if (o_log[ob + i] !== DW'(exp_q[i])) begin bad++; $display("FAIL ovr_out[%0d] got %0d want %0d", i, o_log[ob + i], exp_q[i]); end
      total++; if (l_cyc[ob + i] - v_cyc[xb + i] != 3) begin bad++; $display("FAIL ovr_latency[%0d] got %0d want 3", i, l_cyc[ob + i] - v_cyc[xb + i]); end
    end
  endtask

  task automatic test_reset_mid();
    int t, nload;
    do_reset();
    delay = AW'(0);
    set_stim(700, 4, 1, 0, 0);
    run_samples(4, 1'b0);
    total++; if (dac_data !== 10'd703) begin bad++; $display("FAIL mid_pre_dac got %0d want 703", dac_data); end
    @(posedge sysclk);
    #1 enable = 1'b1;
    t = 0;
    while (adc_valid !== 1'b1 && t < 40) begin
      @(negedge sysclk);
      t++;
    end
    total++; if (adc_valid !== 1'b1) begin bad++; $display("FAIL mid_valid_timeout got %b want 1", adc_valid); end
    nload = o_log.size();
    @(posedge sysclk);
    #1;
    rst_n  = 1'b0;
    enable = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    total++; if (dac_load !== 1'b0) begin bad++; $display("FAIL mid_dac_load got %b want 0", dac_load); end
    total++; if (dac_data !== 10'd512) begin bad++; $display("FAIL mid_dac_data got %0d want 512", dac_data); end
    total++; if (fill !== 4'd0) begin bad++; $display("FAIL mid_fill got %0d want 0", fill); end
    total++; if (adc_start !== 1'b0) begin bad++; $display("FAIL mid_adc_start got %b want 0", adc_start); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL mid_overrun got %b want 0", overrun); end
    repeat (6) @(negedge sysclk);
    total++; if (o_log.size() != nload) begin bad++; $display("FAIL mid_no_load got %0d loads want 0", o_log.size() - nload); end
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    delay  = '0;
    test_reset();
    test_ramp();
    test_random_delay();
    test_wrap();
    test_echo();
    test_saturation();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_delay_proc.md
# audio_delay_proc

Parametrised sample-rate audio delay/echo engine between the SPI ADC and SPI DAC/PWM back-ends. It generates the sample tick and ADC start strobe, accepts each converted sample over a start/valid handshake, and stores it in a circular buffer of 2^AW samples. It returns the sample delayed by a runtime-selectable number of periods, optionally with recursive echo feedback, as a DAC word with a load strobe.

## Interface
Parameters:
- DW, 10: sample width, offset-binary at ports, two's complement internally
- AW, 13: buffer address width; depth 2^AW samples
- CLK_DIV, 2500: sysclk cycles per sample period (20 kHz at 50 MHz); must be ≥ 8

Ports:
- sysclk  in  1  system clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  run; low stops new conversions after the current sample completes
- delay  in  AW  delay in sample periods, 0..2^AW-1
- adc_start  out  1  one-cycle strobe requesting a conversion
- adc_data  in  DW  converted sample, offset-binary
- adc_valid  in  1  one-cycle strobe; adc_data valid this cycle
- dac_data  out  DW  output sample, offset-binary, held between updates
- dac_load  out  1  one-cycle strobe when dac_data changes
- overrun  out  1  sticky: tick arrived while previous sample still pending
- fill  out  AW  samples written since reset, saturating at 2^AW-1

## Operation
- Divider: tick counter 0..CLK_DIV-1, held at 0 while enable=0. tick = (count==CLK_DIV-1).
- FSM states: IDLE, WAIT_ADC, READ, CALC, WRITE.
  - IDLE: tick → assert adc_start, go to WAIT_ADC.
  - WAIT_ADC: adc_valid → latch xs = adc_data − 2^(DW-1), sample delay, and issue buffer read at rd_addr = wr_ptr − delay (mod 2^AW); go to READ.
  - READ → CALC: buffer read data is registered (synchronous RAM).
  - CALC: yd = (fill < delay or delay==0) ? 0 : read data. Compute ys per configuration; go to WRITE.
  - WRITE: write the stored value at wr_ptr; wr_ptr+1 wraps at 2^AW; fill+1 saturates. dac_data = out + 2^(DW-1), pulse dac_load; go to IDLE.
- Output: delay=0 gives out = xs, a pass-through with no echo term.
- Arithmetic: all internal values signed DW bits. Sums are computed at DW+1 bits and saturate to [−2^(DW-1), 2^(DW-1)−1].
- A tick outside IDLE sets overrun. adc_start is suppressed for that tick and the FSM is unaffected.
- adc_valid outside WAIT_ADC is ignored.
- overrun clears only on reset.
- Buffer contents are not reset; fill gating masks stale data.

## Timing
- Reset values: adc_start=0, dac_load=0, overrun=0, fill=0, dac_data=2^(DW-1) (mid-scale). wr_ptr=0, FSM=IDLE, tick count=0.
- Reset mid-sample returns to IDLE with no write and no dac_load.
- adc_start fires on the cycle count==CLK_DIV-1, while in IDLE with enable=1.
- adc_valid at cycle t → dac_load at cycle t+3, with dac_data valid from t+3 onward.
- Simultaneous tick and WRITE cycle: counts as overrun.
- Simultaneous adc_valid and enable falling edge: the sample completes normally.
- delay is sampled only on the adc_valid cycle. Changes at other times take effect on the next sample.
- Wrap-around: wr_ptr 2^AW−1 → 0. rd_addr subtraction is modulo 2^AW.

## Configuration
- Macro AUDIO_DELAY_ECHO_EN.
- Defined: recursive echo. ys = sat(xs + (yd >>> 1)). The buffer stores ys, and out = ys, so y[n] = x[n] + 0.5·y[n−delay].
- Undefined: pure delay. The buffer stores xs, and out = yd. The output is mid-scale until fill ≥ delay. No adder is synthesised.

## Test plan
Bench parameters: DW=10, AW=4, CLK_DIV=8. The ADC model returns valid 2 cycles after start.
- Reset/idle: hold rst_n=0 for 3 cycles, then enable=0 for 40 cycles → dac_data=512, no adc_start, overrun=0, fill=0.
- Pure delay (macro off), delay=3, ramp inputs 600,601,602,… → first 3 dac_data=512, then 600,601,…. Each dac_load occurs exactly 3 cycles after adc_valid.
- Wrap-around: run 40 samples at delay=15 → output equals the input 15 samples earlier across the pointer wrap; fill saturates at 15.
- Echo (macro on), delay=2, single impulse 768 then constant 512 → outputs 768, 512, 640, 512, 576, 512, 544….
  - Saturation case: constant 1023 yields 1023, never a wrap-around value.
- Overrun: ADC model withholds adc_valid for 12 cycles → overrun=1 and stays set. The missed tick produces no adc_start.
- Reset mid-sample: assert rst_n=0 during the READ state → no dac_load; all outputs return to reset values on the next cycle.
